ttl_bus_grant_sequencer: RTL and testbench

- Synchronous round-robin arbiter that shares one bus between four active-low requesters.
- Grant is presented in 74155 form: select lines A and B plus a strobe G_n. An internal 74155 decode turns these into one-hot active-low grants GNT_n[3:0].
- Sits between the board-level request lines and the bus-driver enables. Guarantees break-before-make between owners, a minimum hold time and an optional maximum hold time.

---
 rtl/ttl_bus_grant_sequencer_pkg.sv | 27 ++
 rtl/ttl_74155.sv | 25 ++
 rtl/ttl_bus_grant_sequencer.sv | 149 ++++++++++++++
 tb/tb_ttl_bus_grant_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ttl_bus_grant_sequencer_pkg.sv
// Shared definitions for the bus grant sequencer: state encoding,
// requester count and the round-robin winner search.
package ttl_bus_grant_sequencer_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    // First requesting index after 'last', wrapping mod 4. 'last' itself is
    // checked last so the previous owner has the lowest priority.
    // Returns 'last' when nothing is requesting; callers gate with |req.
    function automatic logic [1:0] rr_next(input logic [1:0]         last,
                                           input logic [NUM_REQ-1:0] req);
        logic [1:0] idx;
        rr_next = last;
        // Scan from the farthest candidate to the nearest so the nearest wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/ttl_74155.sv
// Dual 2-to-4 line decoder/demultiplexer, 74155 behaviour.
// Channel 1 is enabled by C high and G_n low; channel 2 by C_n low and
// G_n low. Both channels share the A/B select inputs. Outputs active low.
module ttl_74155 (
    input  logic       A,
    input  logic       B,
    input  logic       _1C,
    input  logic       _1G_n,
    input  logic       _2C_n,
    input  logic       _2G_n,
    output logic [3:0] _1Y,
    output logic [3:0] _2Y
);

    // Decode both channels from the shared select lines.
    always_comb begin
        _1Y = 4'b1111;
        _2Y = 4'b1111;
        if (_1C && !_1G_n)
            _1Y[{B, A}] = 1'b0;
        if (!_2C_n && !_2G_n)
            _2Y[{B, A}] = 1'b0;
    end

endmodule

// File: rtl/ttl_bus_grant_sequencer.sv
// Round-robin arbiter sharing one bus among four active-low requesters.
// The grant is held in 74155 form (A, B, G_n) and decoded to one-hot
// active-low GNT_n. Break-before-make is enforced by a GAP phase in which
// G_n is high while A/B keep the old owner, so the decoder never glitches.
module ttl_bus_grant_sequencer
    import ttl_bus_grant_sequencer_pkg::*;
#(
    parameter int MIN_HOLD   = 2,
    parameter int MAX_HOLD   = 15,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 4
) (
    input  logic               CLK,
    input  logic               CLR_n,
    input  logic [NUM_REQ-1:0] REQ_n,
    output logic               A,
    output logic               B,
    output logic               G_n,
    output logic [NUM_REQ-1:0] GNT_n,
    output logic               BUSY,
    output logic               FORCED
);

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t             state, state_nxt;
    logic [1:0]         sel, sel_nxt;     // current/last {B,A}
    logic [1:0]         last, last_nxt;   // round-robin pointer
    logic               g_n_r, g_n_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;     // hold counter, 1 in first grant cycle
    logic [CNT_W-1:0]   gcnt, gcnt_nxt;   // gap counter, 0 in first gap cycle
    logic               busy_r, busy_nxt;
    logic               forced_r, forced_nxt;

    logic [NUM_REQ-1:0] req;
    logic               any_req;
    logic [1:0]         win;
    logic               rel_norm;
    logic               rel_force;
    logic [NUM_REQ-1:0] unused_y2;

    assign req       = ~REQ_n;
    assign any_req   = |req;
    assign win       = rr_next(last, req);
    assign rel_norm  = REQ_n[sel] && (cnt >= MIN_C);
    assign rel_force = (MAX_HOLD != 0) && (cnt == MAX_C);

    // State register; reset raises G_n at once, independent of the clock.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state    <= IDLE;
            sel      <= 2'd0;
            last     <= 2'd3;
            g_n_r    <= 1'b1;
            cnt      <= '0;
            gcnt     <= '0;
            busy_r   <= 1'b0;
            forced_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            last     <= last_nxt;
            g_n_r    <= g_n_nxt;
            cnt      <= cnt_nxt;
            gcnt     <= gcnt_nxt;
            busy_r   <= busy_nxt;
            forced_r <= forced_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE or on the last GAP cycle, release
    // a grant on request drop (after MIN_HOLD) or on hitting MAX_HOLD.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        last_nxt   = last;
        g_n_nxt    = g_n_r;
        cnt_nxt    = cnt;
        gcnt_nxt   = gcnt;
        forced_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    sel_nxt   = win;
                    last_nxt  = win;
                    g_n_nxt   = 1'b0;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (rel_norm || rel_force) begin
                    state_nxt  = GAP;
                    g_n_nxt    = 1'b1;
                    gcnt_nxt   = '0;
                    // Only flag a release the requester did not ask for.
                    forced_nxt = rel_force && !rel_norm;
                end else if (cnt != CNT_SAT) begin
                    // Saturate so an unlimited hold never wraps below MIN_HOLD.
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    if (any_req) begin
                        state_nxt = GRANT;
                        sel_nxt   = win;
                        last_nxt  = win;
                        g_n_nxt   = 1'b0;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gcnt_nxt = gcnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                g_n_nxt   = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign A      = sel[0];
    assign B      = sel[1];
    assign G_n    = g_n_r;
    assign BUSY   = busy_r;
    assign FORCED = forced_r;

    // Output decoder: channel 1 drives the grants, channel 2 parked inactive.
    ttl_74155 u_dec (
        .A     (sel[0]),
        .B     (sel[1]),
        ._1C   (1'b1),
        ._1G_n (g_n_r),
        ._2C_n (1'b1),
        ._2G_n (1'b1),
        ._1Y   (GNT_n),
        ._2Y   (unused_y2)
    );

endmodule

// File: tb/tb_ttl_bus_grant_sequencer.sv
// Bench for ttl_bus_grant_sequencer: table of per-cycle vectors through a
// scoreboard queue, plus hand-written rotation, async-reset and
// unlimited-hold sequences. A second instance runs with MAX_HOLD=0.
module tb_ttl_bus_grant_sequencer;

    logic       CLK = 1'b0;
    logic       CLR_n;
    logic [3:0] REQ_n, REQ0_n;
    logic       A, B, G_n, BUSY, FORCED;
    logic [3:0] GNT_n;
    logic       a0, b0, gn0, busy0, forced0;
    logic [3:0] gnt0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] req_n;
        logic [3:0] gnt_n;
        logic       g_n;
        logic [1:0] ba;
        logic       busy;
        logic       forced;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    ttl_bus_grant_sequencer #(.MIN_HOLD(2), .MAX_HOLD(15), .GAP_CYCLES(1), .CNT_W(4)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .REQ_n(REQ_n),
        .A(A), .B(B), .G_n(G_n), .GNT_n(GNT_n), .BUSY(BUSY), .FORCED(FORCED)
    );

    ttl_bus_grant_sequencer #(.MIN_HOLD(2), .MAX_HOLD(0), .GAP_CYCLES(1), .CNT_W(4)) dut0 (
        .CLK(CLK), .CLR_n(CLR_n), .REQ_n(REQ0_n),
        .A(a0), .B(b0), .G_n(gn0), .GNT_n(gnt0), .BUSY(busy0), .FORCED(forced0)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] gnt, input logic g,
                                input logic [1:0] ba, input logic busy, input logic frc);
        vec_t v;
        v.req_n = rq; v.gnt_n = gnt; v.g_n = g; v.ba = ba; v.busy = busy; v.forced = frc;
        return v;
    endfunction

    // Drive one cycle of requests, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string name);
        vec_t e;
        REQ_n = v.req_n;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check(name, {7'd0, GNT_n, G_n, B, A, BUSY, FORCED},
                    {7'd0, e.gnt_n, e.g_n, e.ba, e.busy, e.forced});
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset();
        @(negedge CLK);
        CLR_n = 1'b0;
        #2;
        CLR_n = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        CLR_n  = 1'b0;
        REQ_n  = 4'b1111;
        REQ0_n = 4'b1111;

        // Idle + test 1 (owner 0, held 6 cycles) + test 3 (1-cycle pulse on 2)
        // + test 4 (3 beats 0 after a grant on 1).
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd0, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd0, 0, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(4'b1110, 4'b1110, 0, 2'd0, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd0, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd0, 0, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd0, 0, 0));
        tbl.push_back(mk(4'b1011, 4'b1011, 0, 2'd2, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1011, 0, 2'd2, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd2, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd2, 0, 0));
        tbl.push_back(mk(4'b1101, 4'b1101, 0, 2'd1, 1, 0));
        tbl.push_back(mk(4'b0100, 4'b1101, 0, 2'd1, 1, 0));
        tbl.push_back(mk(4'b0110, 4'b1111, 1, 2'd1, 1, 0));
        tbl.push_back(mk(4'b0110, 4'b0111, 0, 2'd3, 1, 0));
        tbl.push_back(mk(4'b1110, 4'b0111, 0, 2'd3, 1, 0));
        tbl.push_back(mk(4'b1110, 4'b1111, 1, 2'd3, 1, 0));
        tbl.push_back(mk(4'b1110, 4'b1110, 0, 2'd0, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1110, 0, 2'd0, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd0, 1, 0));
        tbl.push_back(mk(4'b1111, 4'b1111, 1, 2'd0, 0, 0));

        // Reset state of both instances.
        #12;
        check("reset_main", {7'd0, GNT_n, G_n, B, A, BUSY, FORCED}, {7'd0, 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0});
        check("reset_unl",  {7'd0, gnt0, gn0, b0, a0, busy0, forced0}, {7'd0, 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0});
        @(negedge CLK);
        CLR_n = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Test 2: all requesting, forced rotation 0,1,2,3,0 with 1-cycle gaps.
        pulse_reset();
        for (int g = 0; g < 5; g++) begin
            logic [1:0] own;
            logic [3:0] one;
            own = 2'(g % 4);
            one = 4'b0001 << own;
            for (int c = 0; c < 15; c++)
                step(mk(4'b0000, ~one, 0, own, 1, 0), $sformatf("rot%0d_hold%0d", g, c));
            step(mk(4'b0000, 4'b1111, 1, own, 1, 1), $sformatf("rot%0d_gap", g));
        end

        // Test 5: asynchronous reset in the middle of a grant on 2.
        REQ_n = 4'b1111;
        pulse_reset();
        step(mk(4'b1011, 4'b1011, 0, 2'd2, 1, 0), "t5_grant2");
        #2;
        CLR_n = 1'b0;
        #1;
        check("t5_async_drop", {7'd0, GNT_n, G_n, B, A, BUSY, FORCED}, {7'd0, 4'b1111, 1'b1, 2'b00, 1'b0, 1'b0});
        #2;
        CLR_n = 1'b1;
        step(mk(4'b0010, 4'b1110, 0, 2'd0, 1, 0), "t5_first_is_0");
        step(mk(4'b1111, 4'b1110, 0, 2'd0, 1, 0), "t5_hold");
        step(mk(4'b1111, 4'b1111, 1, 2'd0, 1, 0), "t5_release");
        step(mk(4'b1111, 4'b1111, 1, 2'd0, 0, 0), "t5_idle");

        // Test 6: unlimited hold keeps requester 3 for 40 cycles, no FORCED.
        pulse_reset();
        REQ0_n = 4'b0111;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            check($sformatf("unl_hold%0d", c), {10'd0, gnt0, gn0, forced0}, {10'd0, 4'b0111, 1'b0, 1'b0});
        end
        REQ0_n = 4'b1111;
        @(posedge CLK);
        #1;
        check("unl_release", {8'd0, gnt0, gn0, b0, a0, forced0}, {8'd0, 4'b1111, 1'b1, 2'b11, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
